loop_unit: RTL and testbench

LOOP_UNIT -- requirements
Module: loop_unit

---
 rtl/loop_unit.sv | 161 ++++++++++++++++
 tb/tb_loop_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_unit.sv
// rtl/loop_unit.sv - bracket-loop control unit: loop-return stack, forward skip scan, PC redirect
//
// Purpose:
//   Executes loop-open / loop-close opcodes for a fetch/execute pipeline.
//   An open with a non-zero cell pushes its PC on a return stack. An open
//   with a zero cell starts a forward scan to the matching close. A close
//   with a non-zero cell redirects fetch to the instruction after the
//   matching open. A close with a zero cell pops the stack.
//   All registered state moves only on a rising clk with advance=1.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   instruction  in   current opcode from fetch
//   pc           in   address of the current instruction
//   advance      in   current instruction retires this cycle
//   cell_zero    in   data cell at head is zero
//   pc_src       out  select pc_loaded in the fetch PC mux
//   pc_loaded    out  branch target (zero when pc_src=0)
//   skipping     out  forward scan active; suppress execution downstream
//   stack_level  out  entries on the return stack
//   overflow     out  sticky: push on full stack or skip counter saturation
//   underflow    out  sticky: close with empty stack

module loop_unit #(
   parameter int                     PC_WIDTH    = 16,
   parameter int                     INSTR_WIDTH = 9,
   parameter int                     STACK_DEPTH = 16,
   parameter int                     SKIP_WIDTH  = 8,
   parameter logic [INSTR_WIDTH-1:0] OP_OPEN     = 9'h005,
   parameter logic [INSTR_WIDTH-1:0] OP_CLOSE    = 9'h006
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [INSTR_WIDTH-1:0]         instruction,
   input  logic [PC_WIDTH-1:0]            pc,
   input  logic                           advance,
   input  logic                           cell_zero,
   output logic                           pc_src,
   output logic [PC_WIDTH-1:0]            pc_loaded,
   output logic                           skipping,
   output logic [$clog2(STACK_DEPTH):0]   stack_level,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int AW = $clog2(STACK_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_SKIP = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [LW-1:0]           level_q, level_d;
   logic [SKIP_WIDTH-1:0]   skip_q, skip_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic                    push;
   logic [PC_WIDTH-1:0]     stack_q [STACK_DEPTH];

   logic [AW-1:0]           top_idx;
   logic [PC_WIDTH-1:0]     stack_top;
   logic                    stack_empty;
   logic                    stack_full;
   logic                    branch;

   // When full, level[AW-1:0] wraps to 0 so subtracting one still lands
   // on the last entry.
   assign top_idx     = level_q[AW-1:0] - AW'(1);
   assign stack_top   = stack_q[top_idx];
   assign stack_empty = (level_q == '0);
   assign stack_full  = (level_q == LW'(STACK_DEPTH));

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      skip_d  = skip_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      branch  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (instruction == OP_OPEN) begin
               if (cell_zero) begin
                  state_d = ST_SKIP;
                  skip_d  = SKIP_WIDTH'(1);
               end else if (stack_full) begin
                  ovf_d = 1'b1;
               end else begin
                  push    = 1'b1;
                  level_d = level_q + LW'(1);
               end
            end else if (instruction == OP_CLOSE) begin
               if (stack_empty) begin
                  unf_d = 1'b1;
               end else if (cell_zero) begin
                  level_d = level_q - LW'(1);
               end else begin
                  branch = 1'b1;
               end
            end
         end
         ST_SKIP: begin
            // Only bracket nesting is tracked; the stack is left alone.
            if (instruction == OP_OPEN) begin
               if (skip_q == '1) begin
                  ovf_d = 1'b1;
               end else begin
                  skip_d = skip_q + SKIP_WIDTH'(1);
               end
            end else if (instruction == OP_CLOSE) begin
               if (skip_q == SKIP_WIDTH'(1)) begin
                  state_d = ST_RUN;
                  skip_d  = '0;
               end else begin
                  skip_d = skip_q - SKIP_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Reset masks the combinational outputs immediately.
      pc_src    = branch && !reset;
      pc_loaded = pc_src ? (stack_top + PC_WIDTH'(1)) : '0;
   end

   assign skipping    = (state_q == ST_SKIP) && !reset;
   assign stack_level = level_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         level_q <= '0;
         skip_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (advance) begin
         state_q <= state_d;
         level_q <= level_d;
         skip_q  <= skip_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents carry no reset; push is only raised when not full, so
   // the low AW bits of level_q address the next free slot.
   always_ff @(posedge clk) begin
      if (!reset && advance && push) begin
         stack_q[level_q[AW-1:0]] <= pc;
      end
   end

endmodule

// File: tb/tb_loop_unit.sv
// tb/tb_loop_unit.sv - directed self-checking bench for loop_unit

module tb_loop_unit;

   localparam logic [8:0] OPEN  = 9'h005;
   localparam logic [8:0] CLOSE = 9'h006;
   localparam logic [8:0] NOP   = 9'h003;

   logic        clk;
   logic        reset;
   logic [8:0]  instruction;
   logic [15:0] pc;
   logic        advance;
   logic        cell_zero;
   logic        pc_src;
   logic [15:0] pc_loaded;
   logic        skipping;
   logic [4:0]  stack_level;
   logic        overflow;
   logic        underflow;

   int n_checks = 0;
   int n_fails  = 0;

   loop_unit dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .pc          (pc),
      .advance     (advance),
      .cell_zero   (cell_zero),
      .pc_src      (pc_src),
      .pc_loaded   (pc_loaded),
      .skipping    (skipping),
      .stack_level (stack_level),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [8:0] op, input logic [15:0] p, input logic adv, input logic cz);
      instruction = op;
      pc          = p;
      advance     = adv;
      cell_zero   = cz;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      drive(NOP, 16'h0000, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(CLOSE, 16'h0000, 1'b1, 1'b0);
      tick();
      tick();
      n_checks++;
      if ({pc_src, pc_loaded, skipping} !== 18'h0) begin
         n_fails++;
         $display("FAIL reset_outputs: got pc_src=%0b pc_loaded=%h skipping=%0b, expected all zero", pc_src, pc_loaded, skipping);
      end
      n_checks++;
      if ({stack_level, overflow, underflow} !== 7'h0) begin
         n_fails++;
         $display("FAIL reset_state: got level=%0d ovf=%0b unf=%0b, expected 0 0 0", stack_level, overflow, underflow);
      end
      reset = 1'b0;
      drive(NOP, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_loop_back;
      apply_reset();
      drive(OPEN, 16'h0010, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b0) begin
         n_fails++;
         $display("FAIL open_pc_src: got %0b expected 0", pc_src);
      end
      tick();
      n_checks++;
      if (stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL open_push_level: got %0d expected 1", stack_level);
      end
      drive(CLOSE, 16'h0014, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b1 || pc_loaded !== 16'h0011) begin
         n_fails++;
         $display("FAIL loop_back_target: got pc_src=%0b pc_loaded=%h expected 1 0011", pc_src, pc_loaded);
      end
      tick();
      n_checks++;
      if (stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL loop_back_level: got %0d expected 1", stack_level);
      end
   endtask

   task automatic test_loop_exit;
      // continues from test_loop_back: one entry (0x0010) on the stack
      drive(NOP, 16'h0015, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b0 || pc_loaded !== 16'h0000) begin
         n_fails++;
         $display("FAIL nop_no_branch: got pc_src=%0b pc_loaded=%h expected 0 0000", pc_src, pc_loaded);
      end
      tick();
      drive(CLOSE, 16'h0014, 1'b1, 1'b1);
      n_checks++;
      if (pc_src !== 1'b0 || pc_loaded !== 16'h0000) begin
         n_fails++;
         $display("FAIL loop_exit_pc_src: got pc_src=%0b pc_loaded=%h expected 0 0000", pc_src, pc_loaded);
      end
      tick();
      n_checks++;
      if (stack_level !== 5'd0 || underflow !== 1'b0) begin
         n_fails++;
         $display("FAIL loop_exit_pop: got level=%0d unf=%0b expected 0 0", stack_level, underflow);
      end
   endtask

   task automatic test_nested_skip;
      apply_reset();
      drive(OPEN, 16'h0020, 1'b1, 1'b1);
      n_checks++;
      if (skipping !== 1'b0 || pc_src !== 1'b0) begin
         n_fails++;
         $display("FAIL skip_entry: got skipping=%0b pc_src=%0b expected 0 0", skipping, pc_src);
      end
      tick();
      drive(OPEN, 16'h0021, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b1 || stack_level !== 5'd0) begin
         n_fails++;
         $display("FAIL skip_inner_open: got skipping=%0b level=%0d expected 1 0", skipping, stack_level);
      end
      tick();
      drive(CLOSE, 16'h0022, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b1 || pc_src !== 1'b0) begin
         n_fails++;
         $display("FAIL skip_inner_close: got skipping=%0b pc_src=%0b expected 1 0", skipping, pc_src);
      end
      tick();
      drive(CLOSE, 16'h0023, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b1 || pc_src !== 1'b0 || stack_level !== 5'd0) begin
         n_fails++;
         $display("FAIL skip_match_close: got skipping=%0b pc_src=%0b level=%0d expected 1 0 0", skipping, pc_src, stack_level);
      end
      tick();
      drive(NOP, 16'h0024, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b0 || stack_level !== 5'd0 || underflow !== 1'b0) begin
         n_fails++;
         $display("FAIL skip_exit: got skipping=%0b level=%0d unf=%0b expected 0 0 0", skipping, stack_level, underflow);
      end
   endtask

   task automatic test_overflow;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(OPEN, 16'h0100 + 16'(i), 1'b1, 1'b0);
         tick();
      end
      n_checks++;
      if (stack_level !== 5'd16 || overflow !== 1'b0) begin
         n_fails++;
         $display("FAIL full_stack: got level=%0d ovf=%0b expected 16 0", stack_level, overflow);
      end
      drive(OPEN, 16'h0110, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (stack_level !== 5'd16 || overflow !== 1'b1) begin
         n_fails++;
         $display("FAIL overflow_push: got level=%0d ovf=%0b expected 16 1", stack_level, overflow);
      end
      drive(CLOSE, 16'h0120, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b1 || pc_loaded !== 16'h0110) begin
         n_fails++;
         $display("FAIL overflow_top: got pc_src=%0b pc_loaded=%h expected 1 0110", pc_src, pc_loaded);
      end
      tick();
      drive(CLOSE, 16'h0120, 1'b1, 1'b1);
      tick();
      drive(CLOSE, 16'h0121, 1'b1, 1'b0);
      n_checks++;
      if (stack_level !== 5'd15 || pc_loaded !== 16'h010F || overflow !== 1'b1) begin
         n_fails++;
         $display("FAIL overflow_after_pop: got level=%0d pc_loaded=%h ovf=%0b expected 15 010f 1", stack_level, pc_loaded, overflow);
      end
   endtask

   task automatic test_underflow;
      apply_reset();
      drive(CLOSE, 16'h0040, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b0 || pc_loaded !== 16'h0000) begin
         n_fails++;
         $display("FAIL underflow_no_branch: got pc_src=%0b pc_loaded=%h expected 0 0000", pc_src, pc_loaded);
      end
      tick();
      n_checks++;
      if (underflow !== 1'b1 || stack_level !== 5'd0) begin
         n_fails++;
         $display("FAIL underflow_set: got unf=%0b level=%0d expected 1 0", underflow, stack_level);
      end
      drive(OPEN, 16'h0041, 1'b1, 1'b0);
      tick();
      drive(NOP, 16'h0042, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (underflow !== 1'b1 || stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL underflow_sticky: got unf=%0b level=%0d expected 1 1", underflow, stack_level);
      end
   endtask

   task automatic test_stall;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(OPEN, 16'h0050, 1'b0, 1'b0);
         tick();
      end
      n_checks++;
      if (stack_level !== 5'd0) begin
         n_fails++;
         $display("FAIL stall_open: got level=%0d expected 0", stack_level);
      end
      drive(CLOSE, 16'h0051, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (underflow !== 1'b0) begin
         n_fails++;
         $display("FAIL stall_close: got unf=%0b expected 0", underflow);
      end
      drive(OPEN, 16'h0052, 1'b1, 1'b0);
      tick();
      drive(CLOSE, 16'h0053, 1'b0, 1'b0);
      n_checks++;
      if (pc_src !== 1'b1 || pc_loaded !== 16'h0053) begin
         n_fails++;
         $display("FAIL stall_comb_branch: got pc_src=%0b pc_loaded=%h expected 1 0053", pc_src, pc_loaded);
      end
      tick();
      n_checks++;
      if (stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL stall_hold_level: got %0d expected 1", stack_level);
      end
   endtask

   task automatic test_reset_in_skip;
      apply_reset();
      drive(OPEN, 16'h0060, 1'b1, 1'b0);
      tick();
      drive(OPEN, 16'h0061, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (skipping !== 1'b1 || stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL pre_reset_skip: got skipping=%0b level=%0d expected 1 1", skipping, stack_level);
      end
      reset = 1'b1;
      drive(CLOSE, 16'h0062, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b0 || pc_src !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_masks_outputs: got skipping=%0b pc_src=%0b expected 0 0", skipping, pc_src);
      end
      tick();
      reset = 1'b0;
      drive(NOP, 16'h0063, 1'b1, 1'b0);
      n_checks++;
      if (skipping !== 1'b0 || stack_level !== 5'd0) begin
         n_fails++;
         $display("FAIL reset_from_skip: got skipping=%0b level=%0d expected 0 0", skipping, stack_level);
      end
   endtask

   task automatic test_back_to_back;
      apply_reset();
      drive(OPEN, 16'h0030, 1'b1, 1'b0);
      tick();
      drive(OPEN, 16'h0031, 1'b1, 1'b0);
      tick();
      drive(CLOSE, 16'h0035, 1'b1, 1'b0);
      n_checks++;
      if (pc_loaded !== 16'h0032) begin
         n_fails++;
         $display("FAIL nested_inner_target: got %h expected 0032", pc_loaded);
      end
      tick();
      drive(CLOSE, 16'h0035, 1'b1, 1'b1);
      tick();
      drive(CLOSE, 16'h0036, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b1 || pc_loaded !== 16'h0031 || stack_level !== 5'd1) begin
         n_fails++;
         $display("FAIL nested_outer_target: got pc_src=%0b pc_loaded=%h level=%0d expected 1 0031 1", pc_src, pc_loaded, stack_level);
      end
      tick();
      drive(OPEN, 16'hFFFF, 1'b1, 1'b0);
      tick();
      drive(CLOSE, 16'h0000, 1'b1, 1'b0);
      n_checks++;
      if (pc_src !== 1'b1 || pc_loaded !== 16'h0000) begin
         n_fails++;
         $display("FAIL pc_wrap_target: got pc_src=%0b pc_loaded=%h expected 1 0000", pc_src, pc_loaded);
      end
      tick();
   endtask

   initial begin
      reset       = 1'b1;
      instruction = NOP;
      pc          = '0;
      advance     = 1'b0;
      cell_zero   = 1'b0;
      test_reset();
      test_loop_back();
      test_loop_exit();
      test_nested_skip();
      test_overflow();
      test_underflow();
      test_stall();
      test_reset_in_skip();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
